// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported, variable-latency memory between the fetch port
// and the data port. Data wins unless a fetch has been passed over STARVE_MAX times.
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4    // legal range 1..15
) (
    input  logic              clk_i,
    input  logic              rst_i,

    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [DATA_W-1:0] if_data_o,
    output logic              if_ready_o,

    input  logic              dm_read_i,
    input  logic              dm_write_i,
    input  logic [ADDR_W-1:0] dm_addr_i,
    input  logic [DATA_W-1:0] dm_wdata_i,
    output logic [DATA_W-1:0] dm_rdata_o,
    output logic              dm_ready_o,

    output logic              if_stall_o,
    output logic              dm_stall_o,

    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              mem_ack_i
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUS_IF = 2'd1,
        BUS_DM = 2'd2,
        RESP   = 2'd3
    } state_t;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_t     state;
    state_t     state_nxt;
    logic [3:0] starve_cnt;
    logic       dm_pend;
    logic       grant_dm;
    logic       grant_if;

    assign dm_pend    = dm_read_i | dm_write_i;
    assign mem_req_o  = (state == BUS_IF) || (state == BUS_DM);
    assign if_stall_o = if_req_i & ~if_ready_o;
    assign dm_stall_o = dm_pend & ~dm_ready_o;

    // NOTE: every signal driven here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        grant_dm  = 1'b0;
        grant_if  = 1'b0;
        case (state)
            IDLE: begin
                if (dm_pend && (!if_req_i || starve_cnt < STARVE_LIM)) begin
                    grant_dm  = 1'b1;
                    state_nxt = BUS_DM;
                end else if (if_req_i) begin
                    grant_if  = 1'b1;
                    state_nxt = BUS_IF;
                end
            end
            BUS_IF, BUS_DM: begin
                if (mem_ack_i) state_nxt = RESP;
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            starve_cnt  <= 4'd0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            if_data_o   <= '0;
            dm_rdata_o  <= '0;
            if_ready_o  <= 1'b0;
            dm_ready_o  <= 1'b0;
        end else begin
            state      <= state_nxt;
            if_ready_o <= (state == BUS_IF) && mem_ack_i;
            dm_ready_o <= (state == BUS_DM) && mem_ack_i;

            if (grant_dm) begin
                mem_addr_o  <= dm_addr_i;
                mem_wdata_o <= dm_wdata_i;
                mem_we_o    <= dm_write_i;
                // Count only data grants that made a waiting fetch lose.
                if (if_req_i && starve_cnt < STARVE_LIM)
                    starve_cnt <= starve_cnt + 4'd1;
            end

            if (grant_if) begin
                mem_addr_o <= if_addr_i;
                mem_we_o   <= 1'b0;
                starve_cnt <= 4'd0;
            end

            if (state == BUS_IF && mem_ack_i)
                if_data_o <= mem_rdata_i;
            // Write completions must not disturb the last read result.
            if (state == BUS_DM && mem_ack_i && !mem_we_o)
                dm_rdata_o <= mem_rdata_i;
        end
    end

endmodule
